// File: rtl/caesar_stream_cipher_pkg.sv
// cipher_pkg: alphabet constants, mode encoding and letter classification shared by the cipher.
package cipher_pkg;
  localparam int ALPHA_N = 26;
  localparam logic [7:0] ASCII_UPPER_A = 8'h41;
  localparam logic [7:0] ASCII_LOWER_A = 8'h61;
  typedef enum logic {MODE_ENC = 1'b0, MODE_DEC = 1'b1} cipher_mode_t;
  function automatic logic is_upper(input logic [7:0] c);
    return c >= ASCII_UPPER_A && c <= ASCII_UPPER_A + 8'd25;
  endfunction
  function automatic logic is_lower(input logic [7:0] c);
    return c >= ASCII_LOWER_A && c <= ASCII_LOWER_A + 8'd25;
  endfunction
endpackage

// File: rtl/caesar_stream_cipher_if.sv
// caesar_stream_cipher_if: input and output byte-stream handshakes of the cipher.
interface caesar_stream_cipher_if;
  logic in_valid, in_ready, in_mode, in_last, out_valid, out_ready, out_last;
  logic [7:0] in_data, out_data;
  modport master (output in_valid, in_data, in_mode, in_last, out_ready,
                  input in_ready, out_valid, out_data, out_last);
  modport slave (input in_valid, in_data, in_mode, in_last, out_ready,
                 output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/caesar_stream_cipher_mod26_shift.sv
// mod26_shift: combinational modulo-26 add (encrypt) or subtract (decrypt) of a letter index.
module mod26_shift
  import cipher_pkg::*;
(
  input  logic [4:0]   idx_i,
  input  logic [4:0]   shift_i,
  input  cipher_mode_t mode_i,
  output logic [4:0]   res_o
);
  logic [5:0] t;
  always_comb begin
    t = mode_i == MODE_ENC ? {1'b0, idx_i} + {1'b0, shift_i}
                           : {1'b0, idx_i} + 6'(ALPHA_N) - {1'b0, shift_i};
    res_o = t >= 6'(ALPHA_N) ? 5'(t - 6'(ALPHA_N)) : t[4:0];
  end
endmodule

// File: rtl/caesar_stream_cipher.sv
// caesar_stream_cipher: streaming Caesar/Vigenere byte cipher with a registered output stage.
// Define CIPHER_NONALPHA_PASS_EN to pass non-letters through; otherwise they are dropped.
module caesar_stream_cipher
  import cipher_pkg::*;
#(
  parameter int KEY_LEN = 8,
  localparam int KIW = KEY_LEN > 1 ? $clog2(KEY_LEN) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           key_wr_i,
  input  logic [KIW-1:0] key_waddr_i,
  input  logic [4:0]     key_wdata_i,
  input  logic [KIW:0]   key_len_i,
  caesar_stream_cipher_if.slave s
);
`ifdef CIPHER_NONALPHA_PASS_EN
  localparam logic PASS = 1'b1;
`else
  localparam logic PASS = 1'b0;
`endif
  logic [4:0] key_q [KEY_LEN];
  logic [KIW-1:0] idx_q, idx_d, cur;
  logic [KIW:0] len_eff;
  logic [7:0] out_data_q, out_data_d, base;
  logic [4:0] shifted;
  logic out_valid_q, out_last_q, accept, upper, alpha, emit;
  assign s.in_ready  = ~out_valid_q | s.out_ready;
  assign s.out_valid = out_valid_q;
  assign s.out_data  = out_data_q;
  assign s.out_last  = out_last_q;
  assign accept = s.in_valid & s.in_ready;
  assign upper  = is_upper(s.in_data);
  assign alpha  = upper | is_lower(s.in_data);
  assign base   = upper ? ASCII_UPPER_A : ASCII_LOWER_A;
  assign emit   = accept & (alpha | PASS);
  // A stale idx beyond a shortened key wraps to 0 before it is used.
  always_comb begin
    len_eff = key_len_i == '0 ? (KIW+1)'(1)
            : key_len_i > (KIW+1)'(KEY_LEN) ? (KIW+1)'(KEY_LEN) : key_len_i;
    cur = {1'b0, idx_q} >= len_eff ? '0 : idx_q;
    idx_d = key_wr_i | (accept & s.in_last) ? '0
          : !(accept & alpha) ? idx_q
          : {1'b0, cur} + 1'b1 == len_eff ? '0 : cur + 1'b1;
    out_data_d = alpha ? base + {3'b0, shifted} : s.in_data;
  end
  mod26_shift u_shift (
    .idx_i  (5'(s.in_data - base)),
    .shift_i(key_q[cur]),
    .mode_i (cipher_mode_t'(s.in_mode)),
    .res_o  (shifted)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      idx_q       <= '0;
    end else begin
      idx_q <= idx_d;
      if (s.in_ready) out_valid_q <= emit;
      if (emit) begin
        out_data_q <= out_data_d;
        out_last_q <= s.in_last;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) for (int i = 0; i < KEY_LEN; i++) key_q[i] <= '0;
    else if (key_wr_i && 32'(key_waddr_i) < KEY_LEN)
      key_q[key_waddr_i] <= key_wdata_i >= 5'd26 ? key_wdata_i - 5'd26 : key_wdata_i;
  end
endmodule

// File: tb/tb_caesar_stream_cipher.sv
// tb_caesar_stream_cipher: directed and randomized streams compared against a modulo-26 model.
module tb_caesar_stream_cipher;
  import cipher_pkg::*;
  localparam int KEY_LEN = 8;
  localparam int KIW = $clog2(KEY_LEN);
`ifdef CIPHER_NONALPHA_PASS_EN
  localparam bit PASS = 1'b1;
`else
  localparam bit PASS = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_wr = 1'b0;
  logic [KIW-1:0] key_waddr = '0;
  logic [4:0] key_wdata = '0;
  logic [KIW:0] key_len = 1;
  caesar_stream_cipher_if ifc ();
  caesar_stream_cipher #(.KEY_LEN(KEY_LEN)) dut (
    .clk(clk), .rst(rst), .key_wr_i(key_wr), .key_waddr_i(key_waddr),
    .key_wdata_i(key_wdata), .key_len_i(key_len), .s(ifc)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  logic [8:0] exp_q[$];
  logic [7:0] got_q[$];
  int m_key[KEY_LEN];
  int m_idx = 0;
  bit rdy_rand = 1'b0;
  logic [8:0] e;
  logic [7:0] hold;
  string pt = "ATTACKATDAWN";
  string ct = "LXFOPVEFRNHR";
  int lemon[5] = '{11, 4, 12, 14, 13};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_str(input string tag, input string s);
    check({tag, "_len"}, got_q.size(), s.len());
    for (int i = 0; i < s.len() && i < got_q.size(); i++) check(tag, got_q[i], s[i]);
    got_q.delete();
  endtask

  function automatic void model_beat(input logic [7:0] c, input logic m, input logic l);
    int len, base, t;
    len = key_len == 0 ? 1 : (int'(key_len) > KEY_LEN ? KEY_LEN : int'(key_len));
    if (m_idx >= len) m_idx = 0;
    base = (c >= "A" && c <= "Z") ? 'h41 : (c >= "a" && c <= "z") ? 'h61 : -1;
    if (base >= 0) begin
      t = m ? (int'(c) - base - m_key[m_idx] + 26) % 26 : (int'(c) - base + m_key[m_idx]) % 26;
      exp_q.push_back({l, 8'(base + t)});
      m_idx = (m_idx + 1) % len;
    end else if (PASS) exp_q.push_back({l, c});
    if (l) m_idx = 0;
  endfunction

  always @(negedge clk) if (rdy_rand) ifc.out_ready = ($urandom_range(0, 3) != 0);

  // Inputs settle at the falling edge; this sees exactly what the next rising edge will commit.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (ifc.out_valid && ifc.out_ready) begin
        got_q.push_back(ifc.out_data);
        check("out_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("out_data", ifc.out_data, e[7:0]);
          check("out_last", ifc.out_last, e[8]);
        end
      end
      if (ifc.in_valid && ifc.in_ready) model_beat(ifc.in_data, ifc.in_mode, ifc.in_last);
      if (key_wr) begin
        if (int'(key_waddr) < KEY_LEN) m_key[key_waddr] = int'(key_wdata) % 26;
        m_idx = 0;
      end
    end
  end

  task automatic send_kw(input logic [7:0] c, input logic m, input logic l,
                         input logic wr, input logic [KIW-1:0] a, input logic [4:0] d);
    int n = 0;
    @(negedge clk);
    ifc.in_valid = 1'b1; ifc.in_data = c; ifc.in_mode = m; ifc.in_last = l;
    #1;
    while (!ifc.in_ready && n < 100) begin
      @(negedge clk); #1; n++;
    end
    if (n == 100) check("accept_timeout", ifc.in_ready, 1);
    key_wr = wr; key_waddr = a; key_wdata = d;
    @(posedge clk);
    #1 key_wr = 1'b0;
  endtask

  task automatic send(input logic [7:0] c, input logic m, input logic l);
    send_kw(c, m, l, 1'b0, '0, '0);
  endtask

  task automatic idle();
    @(negedge clk);
    ifc.in_valid = 1'b0;
  endtask

  task automatic wr_key(input logic [KIW-1:0] a, input logic [4:0] d);
    @(negedge clk);
    ifc.in_valid = 1'b0; key_wr = 1'b1; key_waddr = a; key_wdata = d;
    @(posedge clk);
    #1 key_wr = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    ifc.in_valid = 1'b0;
    #3;
    while ((exp_q.size() != 0 || ifc.out_valid) && n < 200) begin
      @(negedge clk); #3; n++;
    end
    if (n == 200) check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] c;
    foreach (m_key[i]) m_key[i] = 0;
    ifc.in_valid = 1'b0; ifc.in_data = '0; ifc.in_mode = 1'b0; ifc.in_last = 1'b0;
    ifc.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", ifc.out_valid, 0);
    check("rst_out_data", ifc.out_data, 0);
    check("rst_out_last", ifc.out_last, 0);
    check("rst_in_ready", ifc.in_ready, 1);
    rst = 1'b0;
    ifc.out_ready = 1'b1;

    key_len = 1;
    wr_key(0, 3);
    send("A", MODE_ENC, 0); send("x", MODE_ENC, 0); send("Z", MODE_ENC, 1);
    drain(); check_str("caesar_enc", "DaC");
    send("D", MODE_DEC, 1);
    drain(); check_str("caesar_dec", "A");
    wr_key(0, 29);
    send("A", MODE_ENC, 1);
    drain(); check_str("caesar_key29", "D");

    key_len = 5;
    for (int i = 0; i < 5; i++) wr_key(KIW'(i), 5'(lemon[i]));
    fork
      for (int i = 0; i < pt.len(); i++) send(pt[i], MODE_ENC, i == pt.len() - 1);
      begin
        repeat (4) @(negedge clk);
        ifc.out_ready = 1'b0;
        #3 hold = ifc.out_data;
        for (int j = 0; j < 5; j++) begin
          if (j > 0) begin
            @(negedge clk); #3;
            check("bp_hold", ifc.out_data, hold);
          end
          check("bp_in_ready", ifc.in_ready, 0);
          check("bp_valid", ifc.out_valid, 1);
        end
        @(negedge clk);
        ifc.out_ready = 1'b1;
      end
    join
    drain(); check_str("lemon_enc", ct);
    for (int i = 0; i < ct.len(); i++) send(ct[i], MODE_DEC, i == ct.len() - 1);
    drain(); check_str("lemon_dec", pt);

    send("A", MODE_ENC, 0); send("T", MODE_ENC, 0); send("!", MODE_ENC, 0); send("T", MODE_ENC, 1);
    drain(); check_str("nonalpha", PASS ? "LX!F" : "LXF");

    send("A", MODE_ENC, 0);
    send_kw("A", MODE_ENC, 0, 1'b1, 0, 3);
    send("A", MODE_ENC, 1);
    drain(); check_str("kw_coincide", "LED");

    rdy_rand = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 19) == 0) key_len = (KIW+1)'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) wr_key(KIW'($urandom), 5'($urandom));
      if ($urandom_range(0, 7) == 0) idle();
      c = ($urandom_range(0, 3) == 0) ? 8'($urandom)
        : (($urandom_range(0, 1) == 1) ? 8'h41 : 8'h61) + 8'($urandom_range(0, 25));
      send_kw(c, 1'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
              KIW'($urandom), 5'($urandom));
    end
    drain();
    rdy_rand = 1'b0;
    ifc.out_ready = 1'b0;
    got_q.delete();

    key_len = 1;
    send("H", MODE_ENC, 0);
    idle();
    #3;
    check("pre_rst_valid", ifc.out_valid, 1);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", ifc.out_valid, 0);
    check("midrst_in_ready", ifc.in_ready, 1);
    exp_q.delete();
    got_q.delete();
    foreach (m_key[i]) m_key[i] = 0;
    m_idx = 0;
    @(negedge clk);
    rst = 1'b0;
    ifc.out_ready = 1'b1;
    send("Q", MODE_ENC, 1);
    drain(); check_str("post_rst", "Q");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/caesar_stream_cipher.md
# caesar_stream_cipher

Streaming, parametrised successor to the team's one-hot-letter Caesar encoder. It accepts one ASCII byte per handshake and applies a per-character shift from a programmable key of up to KEY_LEN entries. KEY_LEN = 1 gives Caesar; larger keys give Vigenère. Encrypt and decrypt are selected per beat, letter case is preserved, and each result is delivered through a registered valid/ready output stage. The block sits between a byte source (UART/host FIFO) and a byte sink.

## Interface
- KEY_LEN, 8, maximum key length in entries (≥1)
- KIW, $clog2(KEY_LEN) (min 1), key address/index width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- key_wr  in  1  write key_wdata into key[key_waddr]
- key_waddr  in  KIW  key entry address; writes ≥KEY_LEN ignored
- key_wdata  in  5  shift amount; values 26..31 stored minus 26
- key_len  in  KIW+1  active key length, quasi-static; 0→1, >KEY_LEN→KEY_LEN
- in_valid  in  1  input byte valid
- in_ready  out  1  block can accept
- in_data  in  8  ASCII byte
- in_mode  in  1  0 = encrypt, 1 = decrypt; sampled with the beat
- in_last  in  1  last byte of message
- out_valid  out  1  output byte valid
- out_ready  in  1  sink accepts
- out_data  out  8  processed byte
- out_last  out  1  copy of in_last for the beat

## Operation
- Accept when in_valid & in_ready. in_ready = ~out_valid | out_ready (single output register, no bubble under continuous flow).
- Classification:
  - 'A'..'Z' (0x41–0x5A): base 0x41.
  - 'a'..'z' (0x61–0x7A): base 0x61.
  - Anything else is non-alpha.
- Letter arithmetic is 6-bit, with k = key[idx] and i = ch − base.
  - Encrypt: t = i + k; if t ≥ 26 then t −= 26.
  - Decrypt: t = i + 26 − k; if t ≥ 26 then t −= 26.
  - out = base + t.
- Key index idx (KIW bits, reset 0):
  - Advances only on accepted letter beats. Wraps to 0 when idx+1 = effective key_len.
  - Accepted beat with in_last=1 → idx = 0 after the beat.
  - key_wr (any address) → idx = 0.
- Simultaneous key_wr and accepted beat: the beat uses the old key entry and old idx. idx ends at 0 and the new entry is visible from the next beat.
- key_len changes take effect on the next beat. If idx ≥ new length, the next beat wraps it to 0 before use.
- out_data/out_last hold while out_valid & ~out_ready.

## Timing
- Latency 1 cycle: a beat accepted at edge n is presented with out_valid=1 after edge n.
- Throughput 1 byte/cycle while out_ready=1.
- Reset values:
  - out_valid 0, out_data 0x00, out_last 0, idx 0, all key entries 0.
  - in_ready=1 immediately after reset, since out_valid=0.
- Reset mid-stream: the pending output is discarded and idx/key are cleared. No partial handshake is completed.
- out_valid never drops without out_ready while asserted.

## Configuration
- CIPHER_NONALPHA_PASS_EN defined: non-alpha bytes are emitted unchanged with out_last, and idx does not advance.
- Undefined: non-alpha bytes are accepted (in_ready as usual) and dropped, producing no output beat.
  - If a dropped byte carries in_last=1, idx still resets to 0. That last flag is lost, and the sink must not rely on it.

## Structure
- Package cipher_pkg:
  - ALPHA_N = 26
  - ASCII_UPPER_A = 8'h41, ASCII_LOWER_A = 8'h61
  - typedef enum logic {MODE_ENC=0, MODE_DEC=1} cipher_mode_t
  - function is_upper/is_lower
- Sub-module mod26_shift: combinational; inputs 5-bit letter index, 5-bit shift, mode; output 5-bit result.
- Top holds the key register file, idx counter and output register.

## Test plan
- KEY_LEN=1, key[0]=3, encrypt "A","x","Z" → "D","a","C"; decrypt "D" → "A".
- Key "LEMON" (11,4,12,14,13), key_len=5, encrypt "ATTACKATDAWN" → "LXFOPVEFRNHR"; decrypt back to plaintext with in_last on the final byte.
- With CIPHER_NONALPHA_PASS_EN, key LEMON, "AT!T" → "LX!F" (idx unchanged across '!'). Without the macro, "AT!T" → "LXF".
- Backpressure: hold out_ready=0 for 5 cycles mid-message. Check out_data stable, in_ready=0, no loss or duplication, and correct sequence after release.
- key_wr coincident with an accepted beat: that beat uses the old key, and the next beat uses the new key at idx 0.
- Assert rst during a stream: out_valid falls immediately; after release, key=0 so "Q" encrypts to "Q".
